// File: rtl/linear_proj_pkg.sv
// Shared types and default geometry for the linear projection datapath.
package linear_proj_pkg;

  localparam int ROW_SIZE_MAT_C  = 2;
  localparam int COL_SIZE_MAT_C  = 2;
  localparam int INNER_DIMENSION = 12;
  localparam int BLOCK_SIZE      = 4;

  localparam int INNER_STEPS = INNER_DIMENSION / BLOCK_SIZE;

  // $clog2 of 1 is 0; every counter/address still needs at least one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int ADDR_W_A = clog2_min1(ROW_SIZE_MAT_C * INNER_STEPS);
  localparam int ADDR_W_B = clog2_min1(COL_SIZE_MAT_C * INNER_STEPS);
  localparam int FLAG_W   = clog2_min1(ROW_SIZE_MAT_C * COL_SIZE_MAT_C);

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    DRAIN,
    OUT,
    DONE
  } ctrl_state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } strobe_t;

endpackage

// File: rtl/linear_proj_vpipe.sv
// Delays the core strobes by the buffer read latency so they line up with read data.
module linear_proj_vpipe
  import linear_proj_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  strobe_t d,
  output strobe_t q
);

  strobe_t sr [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/linear_proj_ctrl.sv
// Tile sequencer: walks C tiles row-major, streams A/B chunk reads, hands results downstream.
module linear_proj_ctrl #(
  parameter int ROW_TILES   = linear_proj_pkg::ROW_SIZE_MAT_C,
  parameter int COL_TILES   = linear_proj_pkg::COL_SIZE_MAT_C,
  parameter int INNER_STEPS = linear_proj_pkg::INNER_DIMENSION / linear_proj_pkg::BLOCK_SIZE,
  parameter int RD_LATENCY  = 1,
  parameter int ADDR_W_A    = linear_proj_pkg::clog2_min1(ROW_TILES * INNER_STEPS),
  parameter int ADDR_W_B    = linear_proj_pkg::clog2_min1(COL_TILES * INNER_STEPS),
  parameter int FLAG_W      = linear_proj_pkg::clog2_min1(ROW_TILES * COL_TILES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                a_rd_en,
  output logic [ADDR_W_A-1:0] a_rd_addr,
  output logic                b_rd_en,
  output logic [ADDR_W_B-1:0] b_rd_addr,
  output logic                core_valid,
  output logic                core_first,
  output logic                core_last,
  input  logic                core_out_valid,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FLAG_W-1:0]   out_flag
);

  import linear_proj_pkg::*;

  localparam int RW = clog2_min1(ROW_TILES);
  localparam int CW = clog2_min1(COL_TILES);
  localparam int KW = clog2_min1(INNER_STEPS);
  localparam int NT = ROW_TILES * COL_TILES;

  ctrl_state_t       state, state_nxt;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic [KW-1:0]     k;
  logic [FLAG_W-1:0] tile;
  logic              k_last, tile_last, col_last, feeding;
  strobe_t           strb_in, strb_out;

  assign k_last    = (k == KW'(INNER_STEPS - 1));
  assign tile_last = (tile == FLAG_W'(NT - 1));
  assign col_last  = (col == CW'(COL_TILES - 1));
  assign feeding   = (state == FEED);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FEED;
      FEED:    if (k_last) state_nxt = DRAIN;
      DRAIN:   if (core_out_valid) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = tile_last ? DONE : FEED;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tile index is tracked alongside row/col so out_flag needs no multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      row  <= '0;
      col  <= '0;
      k    <= '0;
      tile <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row  <= '0;
            col  <= '0;
            k    <= '0;
            tile <= '0;
          end
        end
        FEED: k <= k_last ? '0 : k + 1'b1;
        OUT: begin
          if (out_ready && !tile_last) begin
            tile <= tile + 1'b1;
            if (col_last) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    a_rd_en   = feeding;
    b_rd_en   = feeding;
    a_rd_addr = '0;
    b_rd_addr = '0;
    if (feeding) begin
      a_rd_addr = ADDR_W_A'(row) * ADDR_W_A'(INNER_STEPS) + ADDR_W_A'(k);
      b_rd_addr = ADDR_W_B'(col) * ADDR_W_B'(INNER_STEPS) + ADDR_W_B'(k);
    end
    out_valid = (state == OUT);
    out_flag  = out_valid ? tile : '0;
  end

  assign strb_in = '{valid: feeding, first: feeding && (k == '0), last: feeding && k_last};

  linear_proj_vpipe #(
    .DEPTH(RD_LATENCY)
  ) u_vpipe (
    .clk(clk),
    .rst(rst),
    .d  (strb_in),
    .q  (strb_out)
  );

  assign core_valid = strb_out.valid;
  assign core_first = strb_out.first;
  assign core_last  = strb_out.last;

endmodule

// File: tb/tb_linear_proj_ctrl.sv
// Bench: 2x2 tiles with INNER_STEPS=3/RD_LATENCY=1, plus a 2x2 INNER_STEPS=1/RD_LATENCY=2 instance.
module tb_linear_proj_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start0, busy0, done0, a_en0, b_en0, cv0, cf0, cl0, cov0, ov0, ordy0;
  logic [2:0] a_addr0, b_addr0;
  logic [1:0] flag0;
  logic       cov_model0, cov_extra0;
  assign cov0 = cov_model0 | cov_extra0;

  logic       start1, busy1, done1, a_en1, b_en1, cv1, cf1, cl1, cov1, ov1, ordy1;
  logic [0:0] a_addr1, b_addr1;
  logic [1:0] flag1;

  linear_proj_ctrl #(
    .ROW_TILES(2), .COL_TILES(2), .INNER_STEPS(3), .RD_LATENCY(1)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .a_rd_en(a_en0), .a_rd_addr(a_addr0), .b_rd_en(b_en0), .b_rd_addr(b_addr0),
    .core_valid(cv0), .core_first(cf0), .core_last(cl0), .core_out_valid(cov0),
    .out_valid(ov0), .out_ready(ordy0), .out_flag(flag0)
  );

  linear_proj_ctrl #(
    .ROW_TILES(2), .COL_TILES(2), .INNER_STEPS(1), .RD_LATENCY(2)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .a_rd_en(a_en1), .a_rd_addr(a_addr1), .b_rd_en(b_en1), .b_rd_addr(b_addr1),
    .core_valid(cv1), .core_first(cf1), .core_last(cl1), .core_out_valid(cov1),
    .out_valid(ov1), .out_ready(ordy1), .out_flag(flag1)
  );

  typedef struct {
    int   tile;
    int   k;
    int   a;
    int   b;
    logic first;
    logic last;
  } rd_vec_t;

  typedef struct {
    logic first;
    logic last;
    int   due;
  } strb_t;

  rd_vec_t rd_tbl [12];
  rd_vec_t rd1_tbl [4];
  rd_vec_t exp_rd[$];
  rd_vec_t exp_rd1[$];
  strb_t   strb_q[$];
  int      exp_flag[$];
  int      exp_flag1[$];

  int n_chk = 0;
  int n_pass = 0;
  int hs_cnt0 = 0, done_cnt0 = 0, hs_cnt1 = 0, done_cnt1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_run0();
    foreach (rd_tbl[i]) exp_rd.push_back(rd_tbl[i]);
    for (int f = 0; f < 4; f++) exp_flag.push_back(f);
  endtask

  task automatic pulse_start0();
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
  endtask

  task automatic wait_hs0(input int target, input string name);
    int i;
    i = 0;
    while (hs_cnt0 < target && i < 400) begin
      @(posedge clk);
      i++;
    end
    chk(name, hs_cnt0, target);
  endtask

  task automatic wait_done0(input int target, input string name);
    int i;
    i = 0;
    while (done_cnt0 < target && i < 400) begin
      @(posedge clk);
      i++;
    end
    chk(name, done_cnt0, target);
  endtask

  // Core model for dut0: core_out_valid pulses 4 cycles after core_last.
  initial begin
    int cnt;
    cnt = 0;
    cov_model0 = 1'b0;
    forever begin
      @(posedge clk); #2;
      cov_model0 = 1'b0;
      if (rst) cnt = 0;
      else begin
        if (cnt != 0) begin
          cnt--;
          if (cnt == 0) cov_model0 = 1'b1;
        end
        if (cv0 && cl0) cnt = 4;
      end
    end
  end

  initial begin
    int cnt;
    cnt = 0;
    cov1 = 1'b0;
    forever begin
      @(posedge clk); #2;
      cov1 = 1'b0;
      if (rst) cnt = 0;
      else begin
        if (cnt != 0) begin
          cnt--;
          if (cnt == 0) cov1 = 1'b1;
        end
        if (cv1 && cl1) cnt = 4;
      end
    end
  end

  // Scoreboard for dut0: reads pop the expected table and schedule strobe checks.
  initial begin
    int      cyc;
    logic    prev_done, prev_stall;
    logic [1:0] prev_flag;
    rd_vec_t r;
    strb_t   s;
    cyc = 0; prev_done = 1'b0; prev_stall = 1'b0; prev_flag = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        strb_q.delete();
        prev_done = 1'b0;
        prev_stall = 1'b0;
        continue;
      end
      if (strb_q.size() > 0 && strb_q[0].due == cyc) begin
        s = strb_q.pop_front();
        chk("core_valid", cv0, 1);
        chk("core_first", cf0, s.first);
        chk("core_last", cl0, s.last);
      end else if (cv0 || cf0 || cl0) begin
        chk("core_strobe_spurious", {cv0, cf0, cl0}, 0);
      end
      if (a_en0 !== b_en0) chk("rd_en_pair", b_en0, a_en0);
      if (a_en0) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", a_en0, 0);
        else begin
          r = exp_rd.pop_front();
          chk("a_rd_addr", a_addr0, r.a);
          chk("b_rd_addr", b_addr0, r.b);
          s.first = r.first;
          s.last  = r.last;
          s.due   = cyc + 1;
          strb_q.push_back(s);
        end
      end
      if (ov0 && a_en0) chk("rd_during_out", a_en0, 0);
      if (prev_stall) begin
        chk("valid_held", ov0, 1);
        chk("flag_stable", flag0, prev_flag);
      end
      if (ov0 && ordy0) begin
        if (exp_flag.size() == 0) chk("hs_unexpected", ov0, 0);
        else chk("out_flag", flag0, exp_flag.pop_front());
        hs_cnt0++;
      end
      if (prev_done) chk("busy_after_done", busy0, 0);
      if (done0) done_cnt0++;
      prev_stall = ov0 && !ordy0;
      prev_flag  = flag0;
      prev_done  = done0;
    end
  end

  // dut1 monitor: strobes follow a_rd_en by two cycles, first==last==valid.
  initial begin
    logic    h1, h2;
    rd_vec_t r;
    h1 = 1'b0; h2 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        h1 = 1'b0;
        h2 = 1'b0;
        continue;
      end
      if (h2 || cv1 || cf1 || cl1) begin
        chk("l2_core_valid", cv1, h2);
        chk("l2_core_first", cf1, h2);
        chk("l2_core_last", cl1, h2);
      end
      h2 = h1;
      h1 = a_en1;
      if (a_en1) begin
        if (exp_rd1.size() == 0) chk("l2_rd_unexpected", a_en1, 0);
        else begin
          r = exp_rd1.pop_front();
          chk("l2_a_rd_addr", a_addr1, r.a);
          chk("l2_b_rd_addr", b_addr1, r.b);
        end
      end
      if (ov1 && ordy1) begin
        if (exp_flag1.size() == 0) chk("l2_hs_unexpected", ov1, 0);
        else chk("l2_out_flag", flag1, exp_flag1.pop_front());
        hs_cnt1++;
      end
      if (done1) done_cnt1++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_seq [12] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
    int b_seq [12] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
    int a1_seq [4] = '{0, 0, 1, 1};
    int b1_seq [4] = '{0, 1, 0, 1};
    int h;
    int i;

    for (int n = 0; n < 12; n++) begin
      rd_tbl[n].tile  = n / 3;
      rd_tbl[n].k     = n % 3;
      rd_tbl[n].a     = a_seq[n];
      rd_tbl[n].b     = b_seq[n];
      rd_tbl[n].first = (n % 3 == 0);
      rd_tbl[n].last  = (n % 3 == 2);
    end
    for (int n = 0; n < 4; n++) begin
      rd1_tbl[n].tile  = n;
      rd1_tbl[n].k     = 0;
      rd1_tbl[n].a     = a1_seq[n];
      rd1_tbl[n].b     = b1_seq[n];
      rd1_tbl[n].first = 1'b1;
      rd1_tbl[n].last  = 1'b1;
    end

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; ordy0 = 1'b1; ordy1 = 1'b1; cov_extra0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs0", {busy0, done0, a_en0, a_addr0, b_en0, b_addr0, cv0, cf0, cl0, ov0, flag0}, 0);
    chk("reset_outs1", {busy1, done1, a_en1, a_addr1, b_en1, b_addr1, cv1, cf1, cl1, ov1, flag1}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Run 1: plain full matrix
    push_run0();
    pulse_start0();
    @(negedge clk);
    chk("first_rd_latency", a_en0, 1);
    chk("busy_running", busy0, 1);
    @(negedge clk);
    chk("first_core_valid_latency", cv0, 1);
    wait_done0(1, "run1_done");
    repeat (3) @(negedge clk);
    chk("run1_reads_left", exp_rd.size(), 0);
    chk("run1_flags_left", exp_flag.size(), 0);
    chk("run1_busy_idle", busy0, 0);
    chk("run1_done_count", done_cnt0, 1);

    // Run 2: start/core_out_valid during FEED, backpressure on tile 1, start during DONE
    h = hs_cnt0;
    push_run0();
    pulse_start0();
    @(posedge clk); #1 start0 = 1'b1; cov_extra0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0; cov_extra0 = 1'b0;
    wait_hs0(h + 1, "run2_tile0_hs");
    #1 ordy0 = 1'b0;
    i = 0;
    while (!ov0 && i < 60) begin
      @(negedge clk);
      i++;
    end
    chk("stall_out_valid_seen", ov0, 1);
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", ov0, 1);
      chk("stall_flag", flag0, 1);
      chk("stall_no_rd", {a_en0, b_en0}, 0);
      if (c < 4) @(negedge clk);
    end
    @(posedge clk); #1 ordy0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("resume_rd_en", a_en0, 1);
    chk("resume_a_addr", a_addr0, 3);
    wait_hs0(h + 4, "run2_last_hs");
    #1 start0 = 1'b1;
    @(negedge clk);
    chk("run2_done_pulse", done0, 1);
    @(posedge clk); #1 start0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("run2_busy_idle", busy0, 0);
    chk("run2_done_count", done_cnt0, 2);
    chk("run2_reads_left", exp_rd.size(), 0);
    chk("run2_flags_left", exp_flag.size(), 0);

    // Run 3: reset during tile 2 at k=1, then a clean restart
    h = hs_cnt0;
    push_run0();
    pulse_start0();
    wait_hs0(h + 2, "run3_tile1_hs");
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_point_a", a_addr0, 4);
    chk("rst_point_b", b_addr0, 1);
    @(negedge clk);
    chk("midrun_reset_outs", {busy0, done0, a_en0, a_addr0, b_en0, b_addr0, cv0, cf0, cl0, ov0, flag0}, 0);
    exp_rd.delete();
    exp_flag.delete();
    @(posedge clk); #1 rst = 1'b0;
    push_run0();
    pulse_start0();
    wait_done0(3, "run3_done");
    repeat (3) @(negedge clk);
    chk("run3_reads_left", exp_rd.size(), 0);
    chk("run3_flags_left", exp_flag.size(), 0);
    chk("run3_busy_idle", busy0, 0);

    // INNER_STEPS=1, RD_LATENCY=2 instance
    foreach (rd1_tbl[n]) exp_rd1.push_back(rd1_tbl[n]);
    for (int f = 0; f < 4; f++) exp_flag1.push_back(f);
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    i = 0;
    while (done_cnt1 < 1 && i < 400) begin
      @(posedge clk);
      i++;
    end
    chk("l2_done", done_cnt1, 1);
    repeat (3) @(negedge clk);
    chk("l2_tiles", hs_cnt1, 4);
    chk("l2_reads_left", exp_rd1.size(), 0);
    chk("l2_busy_idle", busy1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
